conv2d_mc_stream: RTL

- Parametrised multi-channel 2D convolution engine for the streaming CNN datapath.
- Takes a raster-order single-channel pixel stream and applies OUT_CH kernels of size KxK with stride 1 and no padding.
- Kernels are loaded at run time over a serial port; no fixed ROM file.
- Per channel: adds bias, arithmetic right shift, saturation to OUT_W, and optional ReLU. All channels are emitted in parallel, with frame-last marking.

---
 rtl/cnn_conv_pkg.sv | 33 +++
 rtl/conv_linebuf.sv | 34 +++
 rtl/conv2d_mc_stream.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cnn_conv_pkg.sv
// Shared types and helpers for the streaming convolution engine.
package cnn_conv_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_W_W    = 16;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_OUT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } conv_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/conv_linebuf.sv
// K-1 row line buffer; emits the K-tall window column for the current pixel.
module conv_linebuf
    import cnn_conv_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int DATA_W = 8,
    parameter int K      = 5,
    localparam int COL_W = clog2(IMG_W)
) (
    input  logic                        clk,
    input  logic                        shift_en,
    input  logic [COL_W-1:0]            col,
    input  logic [DATA_W-1:0]           pix,
    output logic [K-1:0][DATA_W-1:0]    column
);

    // mem[0] holds the most recent row, mem[K-2] the oldest.
    logic [DATA_W-1:0] mem [K-1][IMG_W];

    always_comb begin
        column[K-1] = pix;
        for (int i = 0; i < K - 1; i++)
            column[K-2-i] = mem[i][col];
    end

    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int i = K - 2; i > 0; i--)
                mem[i][col] <= mem[i-1][col];
            mem[0][col] <= pix;
        end
    end

endmodule

// File: rtl/conv2d_mc_stream.sv
// Multi-channel KxK stride-1 convolution over a raster pixel stream, 3-cycle latency.
// Define CONV_RELU_EN to clamp negative channel results to zero.
module conv2d_mc_stream
    import cnn_conv_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int DATA_W = DEF_DATA_W,
    parameter int W_W    = DEF_W_W,
    parameter int OUT_CH = 4,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SHIFT  = 8,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_load_start,
    input  logic                      w_load_valid,
    input  logic [W_W-1:0]            w_load_data,
    output logic                      w_ready,
    input  logic [DATA_W-1:0]         pix_in,
    input  logic                      pix_valid,
    input  logic                      pix_sof,
    output logic [OUT_CH*OUT_W-1:0]   conv_out,
    output logic                      conv_out_valid,
    output logic                      conv_out_last
);

    localparam int TAPS   = K * K;
    localparam int WORDS  = OUT_CH * (TAPS + 1);
    localparam int IDX_W  = clog2(WORDS);
    localparam int COL_W  = clog2(IMG_W);
    localparam int ROW_W  = clog2(IMG_H);
    localparam int STAGES = 3;

    conv_state_e state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic load_we;
    logic signed [W_W-1:0] coef [WORDS];

    logic accept, win_ok, win_last;
    logic [COL_W-1:0] col, cur_col;
    logic [ROW_W-1:0] row, cur_row;
    logic [K-1:0][DATA_W-1:0] column;
    logic [DATA_W-1:0] win [K][K];

    logic [STAGES:0] vld_pipe, last_pipe;
    logic [STAGES:1] vld_q, last_q;
    logic [OUT_CH-1:0][OUT_W-1:0] res;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (w_load_start) state_nxt = LOAD;
            LOAD:    if (!w_load_start && w_load_valid && idx == IDX_W'(WORDS - 1))
                         state_nxt = RUN;
            RUN:     if (w_load_start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ready = (state == RUN);
        load_we = (state == LOAD) && w_load_valid && !w_load_start;
    end

    always_ff @(posedge clk) begin
        if (rst || w_load_start) idx <= '0;
        else if (load_we)        idx <= (idx == IDX_W'(WORDS - 1)) ? '0 : idx + 1'b1;
    end

    // Coefficient bank deliberately survives reset.
    always_ff @(posedge clk) begin
        if (load_we) coef[idx] <= w_load_data;
    end

    always_comb begin
        accept   = (state == RUN) && pix_valid && !w_load_start;
        cur_col  = pix_sof ? '0 : col;
        cur_row  = pix_sof ? '0 : row;
        win_ok   = accept && cur_col >= COL_W'(K - 1) && cur_row >= ROW_W'(K - 1);
        win_last = win_ok && cur_col == COL_W'(IMG_W - 1) && cur_row == ROW_W'(IMG_H - 1);
    end

    always_ff @(posedge clk) begin
        if (rst || w_load_start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (cur_col == COL_W'(IMG_W - 1)) begin
                col <= '0;
                row <= (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    conv_linebuf #(.IMG_W(IMG_W), .DATA_W(DATA_W), .K(K)) u_linebuf (
        .clk      (clk),
        .shift_en (accept),
        .col      (cur_col),
        .pix      (pix_in),
        .column   (column)
    );

    // S1: window, row 0 is the oldest line, column K-1 the newest pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    win[r][c] <= '0;
        end else if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++)
                    win[r][c] <= win[r][c+1];
                win[r][K-1] <= column[r];
            end
        end
    end

    assign vld_pipe  = {vld_q, win_ok};
    assign last_pipe = {last_q, win_last};

    always_ff @(posedge clk) begin
        if (rst || w_load_start) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q  <= vld_pipe[STAGES-1:0];
            last_q <= last_pipe[STAGES-1:0];
        end
    end

    function automatic logic [OUT_W-1:0] post(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        logic signed [63:0] s;
        sh = a >>> SHIFT;
        s  = saturate(64'(sh), OUT_W);
`ifdef CONV_RELU_EN
        if (s < 0) s = '0;
`endif
        return s[OUT_W-1:0];
    endfunction

    for (genvar ch = 0; ch < OUT_CH; ch++) begin : g_ch
        localparam int BASE = ch * (TAPS + 1);
        logic signed [ACC_W-1:0] prod [TAPS];
        logic signed [ACC_W-1:0] acc;

        // S2: zero-extended pixel times signed weight.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int t = 0; t < TAPS; t++) prod[t] <= '0;
            end else begin
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        prod[r*K+c] <= ACC_W'($signed({1'b0, win[r][c]}))
                                     * ACC_W'(coef[BASE + r*K + c]);
            end
        end

        always_comb begin
            acc = ACC_W'(coef[BASE + TAPS]);
            for (int t = 0; t < TAPS; t++) acc = acc + prod[t];
        end

        assign res[ch] = post(acc);
    end

    // S3: result register; holds its value between valid outputs.
    always_ff @(posedge clk) begin
        if (rst)              conv_out <= '0;
        else if (vld_pipe[2]) conv_out <= res;
    end

    assign conv_out_valid = vld_q[STAGES];
    assign conv_out_last  = last_q[STAGES];

endmodule
